// File: rtl/mips_pkg.sv
// Shared ISA constants, field widths and ALU/run-state enums for the mips_top processor slice.
package mips_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned TGT_W   = 26;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } run_state_e;

   function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/mips_datapath.sv
// Single-cycle datapath: fetch, decode, ALU, memories, PC and run control.
// Optional halt-on-zero-fetch behaviour is enabled with MIPS_HALT_ON_ZERO_EN.
module mips_datapath
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned DMEM_DEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] i_idata,
   input  logic [XLEN-1:0] i_iaddr,
   input  logic            i_icache_we,
   input  logic [XLEN-1:0] i_ddata,
   input  logic [XLEN-1:0] i_daddr,
   input  logic            i_dcache_we,
   input  logic            i_start,
   output logic            o_running,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr
);

   localparam int unsigned IW = $clog2(IMEM_DEPTH);
   localparam int unsigned DW = $clog2(DMEM_DEPTH);

   logic [XLEN-1:0] r_imem [0:IMEM_DEPTH-1];
   logic [XLEN-1:0] r_dmem [0:DMEM_DEPTH-1];
   logic [IW-1:0]   r_pc;
   run_state_e      r_state;
   logic            r_running;

   logic [XLEN-1:0]    w_instr;
   logic [OP_W-1:0]    w_op;
   logic [REG_W-1:0]   w_rs;
   logic [REG_W-1:0]   w_rt;
   logic [REG_W-1:0]   w_rd;
   logic [FUNCT_W-1:0] w_funct;
   logic [XLEN-1:0]    w_imm_ext;
   logic [XLEN-1:0]    w_rdata_a;
   logic [XLEN-1:0]    w_rdata_b;
   logic [XLEN-1:0]    w_alu_b;
   logic [XLEN-1:0]    w_alu_y;
   logic [XLEN-1:0]    w_dmem_rdata;
   logic [XLEN-1:0]    w_wdata;
   logic [REG_W-1:0]   w_waddr;
   alu_op_e            w_alu_op;
   logic               w_rf_we;
   logic               w_mem_to_reg;
   logic               w_sw;
   logic               w_branch;
   logic               w_jump;
   logic               w_exec;
   logic [IW-1:0]      w_pc_inc;
   logic [IW-1:0]      w_pc_next;
   logic               w_halt;
   logic               w_start_rise;
   logic               w_unused_bits;

`ifdef MIPS_HALT_ON_ZERO_EN
   logic r_start_d;

   always_ff @(posedge clk) begin
      if (!rst) r_start_d <= 1'b0;
      else      r_start_d <= i_start;
   end

   assign w_halt       = (w_instr == '0);
   assign w_start_rise = i_start & ~r_start_d;
`else
   assign w_halt       = 1'b0;
   assign w_start_rise = 1'b0;
`endif

   assign w_instr   = r_imem[r_pc];
   assign w_op      = w_instr[XLEN-1 -: OP_W];
   assign w_rs      = w_instr[25:21];
   assign w_rt      = w_instr[20:16];
   assign w_rd      = w_instr[15:11];
   assign w_funct   = w_instr[FUNCT_W-1:0];
   assign w_imm_ext = sext_imm(w_instr[IMM_W-1:0]);

   mips_regfile reg_file (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_rf_we & w_exec),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (w_rs),
      .i_raddr_b (w_rt),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   always_comb begin
      w_alu_op     = ALU_ADD;
      w_alu_b      = w_rdata_b;
      w_waddr      = w_rt;
      w_rf_we      = 1'b0;
      w_mem_to_reg = 1'b0;
      w_sw         = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_waddr = w_rd;
            case (w_funct)
               FN_ADD:  begin w_alu_op = ALU_ADD; w_rf_we = 1'b1; end
               FN_SUB:  begin w_alu_op = ALU_SUB; w_rf_we = 1'b1; end
               FN_AND:  begin w_alu_op = ALU_AND; w_rf_we = 1'b1; end
               FN_OR:   begin w_alu_op = ALU_OR;  w_rf_we = 1'b1; end
               FN_SLT:  begin w_alu_op = ALU_SLT; w_rf_we = 1'b1; end
               default: ;
            endcase
         end
         OP_ADDI: begin w_alu_b = w_imm_ext; w_rf_we = 1'b1; end
         OP_LW:   begin w_alu_b = w_imm_ext; w_rf_we = 1'b1; w_mem_to_reg = 1'b1; end
         OP_SW:   begin w_alu_b = w_imm_ext; w_sw = 1'b1; end
         OP_BEQ:  w_branch = (w_rdata_a == w_rdata_b);
         OP_BNE:  w_branch = (w_rdata_a != w_rdata_b);
         OP_J:    w_jump = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_alu_y = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_y = w_rdata_a + w_alu_b;
         ALU_SUB: w_alu_y = w_rdata_a - w_alu_b;
         ALU_AND: w_alu_y = w_rdata_a & w_alu_b;
         ALU_OR:  w_alu_y = w_rdata_a | w_alu_b;
         ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, ($signed(w_rdata_a) < $signed(w_alu_b))};
         default: w_alu_y = '0;
      endcase
   end

   assign w_dmem_rdata = r_dmem[w_alu_y[DW-1:0]];
   assign w_wdata      = w_mem_to_reg ? w_dmem_rdata : w_alu_y;
   assign w_exec       = r_running & rst & ~w_halt;

   // Jump target is {6'b0, target26}; only the low IW bits survive PC wrap.
   assign w_pc_inc  = r_pc + 1'b1;
   assign w_pc_next = w_jump   ? w_instr[IW-1:0] :
                      w_branch ? (w_pc_inc + w_imm_ext[IW-1:0]) : w_pc_inc;

   always_ff @(posedge clk) begin
      if (i_icache_we) r_imem[i_iaddr[IW-1:0]] <= i_idata;
   end

   // Loader write is issued last so it wins over a same-word store.
   always_ff @(posedge clk) begin
      if (w_sw && w_exec) r_dmem[w_alu_y[DW-1:0]] <= w_rdata_b;
      if (i_dcache_we)    r_dmem[i_daddr[DW-1:0]] <= i_ddata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
         r_pc      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_halt) begin
                  r_state   <= ST_HALT;
                  r_running <= 1'b0;
               end else begin
                  r_pc <= w_pc_next;
               end
            end
            ST_HALT: begin
               if (w_start_rise) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
                  r_pc      <= w_pc_inc;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign o_running = r_running;
   assign o_pc      = {{(XLEN-IW){1'b0}}, r_pc};
   assign o_instr   = w_instr;

   assign w_unused_bits = ^{i_iaddr[XLEN-1:IW], i_daddr[XLEN-1:DW], w_alu_y[XLEN-1:DW], w_instr[10:6]};

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port, $0 hardwired to zero.
module mips_regfile
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [REG_W-1:0] i_waddr,
   input  logic [XLEN-1:0]  i_wdata,
   input  logic [REG_W-1:0] i_raddr_a,
   input  logic [REG_W-1:0] i_raddr_b,
   output logic [XLEN-1:0]  o_rdata_a,
   output logic [XLEN-1:0]  o_rdata_b
);

   logic [XLEN-1:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : regs[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : regs[i_raddr_b];

endmodule

// File: rtl/mips_top.sv
// Single-cycle word-addressed MIPS-subset processor with loadable instruction/data memories.
// Define MIPS_HALT_ON_ZERO_EN to stop execution when an all-zero word is fetched.
module mips_top
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned DMEM_DEPTH = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] IData_in,
   input  logic [XLEN-1:0] IAddr_in,
   input  logic            icache_we,
   input  logic [XLEN-1:0] DData_in,
   input  logic [XLEN-1:0] DAddr_in,
   input  logic            dcache_we,
   input  logic            start,
   output logic            processor_running,
   output logic [XLEN-1:0] current_pc,
   output logic [XLEN-1:0] current_instruction
);

   mips_datapath #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .DMEM_DEPTH (DMEM_DEPTH)
   ) datapath_inst (
      .clk         (clk),
      .rst         (rst),
      .i_idata     (IData_in),
      .i_iaddr     (IAddr_in),
      .i_icache_we (icache_we),
      .i_ddata     (DData_in),
      .i_daddr     (DAddr_in),
      .i_dcache_we (dcache_we),
      .i_start     (start),
      .o_running   (processor_running),
      .o_pc        (current_pc),
      .o_instr     (current_instruction)
   );

endmodule

// File: tb/tb_mips_top.sv
// Directed and randomized bench for mips_top against an instruction-level reference interpreter.
module tb_mips_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IData_in, IAddr_in, DData_in, DAddr_in;
   logic        icache_we, dcache_we, start;
   logic        processor_running;
   logic [31:0] current_pc, current_instruction;

   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;
   int unsigned n_check = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_dmem [256];
   logic [31:0] m_imem [256];
   int unsigned m_pc;

   mips_top #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .IData_in            (IData_in),
      .IAddr_in            (IAddr_in),
      .icache_we           (icache_we),
      .DData_in            (DData_in),
      .DAddr_in            (DAddr_in),
      .dcache_we           (dcache_we),
      .start               (start),
      .processor_running   (processor_running),
      .current_pc          (current_pc),
      .current_instruction (current_instruction)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_check++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] rnd;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fns [6];
      int unsigned k;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
      rnd = $urandom;
      rs  = rnd[4:0];
      rt  = rnd[9:5];
      rd  = rnd[14:10];
      k   = $urandom_range(0, 11);
      rnd = $urandom;
      case (k)
         0, 1, 2, 3, 4: return enc_r(rs, rt, rd, fns[k]);
         5:  return enc_i(6'h08, rs, rt, rnd[15:0]);
         6:  return enc_i(6'h23, rs, rt, rnd[15:0]);
         7:  return enc_i(6'h2B, rs, rt, rnd[15:0]);
         8:  return enc_i(6'h04, rs, (rnd[20] ? rs : rt), 16'(int'($urandom_range(0, 15)) - 8));
         9:  return enc_i(6'h05, rs, (rnd[20] ? rs : rt), 16'(int'($urandom_range(0, 15)) - 8));
         10: return enc_j(rnd[25:0]);
         default: return {6'h3F, rnd[25:0]};
      endcase
   endfunction

   // Architectural interpreter: one call retires one instruction.
   function automatic void m_step();
      logic [31:0] ins, a, b, sx;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      int unsigned nxt;
      ins = m_imem[m_pc];
      op  = ins[31:26];
      rs  = ins[25:21];
      rt  = ins[20:16];
      rd  = ins[15:11];
      fn  = ins[5:0];
      a   = m_regs[rs];
      b   = m_regs[rt];
      sx  = {{16{ins[15]}}, ins[15:0]};
      nxt = (m_pc + 1) % 256;
      case (op)
         6'h00: case (fn)
            6'h20: m_regs[rd] = a + b;
            6'h22: m_regs[rd] = a - b;
            6'h24: m_regs[rd] = a & b;
            6'h25: m_regs[rd] = a | b;
            6'h2A: m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ;
         endcase
         6'h08: m_regs[rt] = a + sx;
         6'h23: m_regs[rt] = m_dmem[(a + sx) % 256];
         6'h2B: m_dmem[(a + sx) % 256] = b;
         6'h04: if (a == b) nxt = (m_pc + 1 + sx) % 256;
         6'h05: if (a != b) nxt = (m_pc + 1 + sx) % 256;
         6'h02: nxt = ins[25:0] % 256;
         default: ;
      endcase
      m_regs[0] = '0;
      m_pc = nxt;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = 0;
   endfunction

   task automatic load_i(input int unsigned addr, input logic [31:0] data);
      IAddr_in  = addr;
      IData_in  = data;
      icache_we = 1'b1;
      tick();
      icache_we = 1'b0;
      m_imem[addr % 256] = data;
   endtask

   task automatic load_d(input int unsigned addr, input logic [31:0] data);
      DAddr_in  = addr;
      DData_in  = data;
      dcache_we = 1'b1;
      tick();
      dcache_we = 1'b0;
      m_dmem[addr % 256] = data;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [31:0] arr [10];
      logic [31:0] exp_max;
      int unsigned exp_seq [15];

      rst = 1'b0; start = 1'b0; icache_we = 1'b0; dcache_we = 1'b0;
      IData_in = '0; IAddr_in = '0; DData_in = '0; DAddr_in = '0;
      m_reset();
      tick();
      tick();

      for (int a = 0; a < 256; a++) begin
         load_i(a, rand_instr());
         load_d(a, $urandom);
      end
      check("rst_pc", current_pc, 32'd0);
      check("rst_running", 32'(processor_running), 32'd0);
      check("rst_reg1", dut.datapath_inst.reg_file.regs[1], 32'd0);
      check("rst_reg31", dut.datapath_inst.reg_file.regs[31], 32'd0);
      check("rst_instr", current_instruction, m_imem[0]);

      rst = 1'b1;
      repeat (20) tick();
      check("idle_pc", current_pc, 32'd0);
      check("idle_running", 32'(processor_running), 32'd0);
      for (int i = 0; i < 32; i++) check("idle_regs", dut.datapath_inst.reg_file.regs[i], 32'd0);

      load_i(0,  enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD));
      load_i(1,  enc_r(5'd1, 5'd0, 5'd2, 6'h2A));
      load_i(2,  enc_r(5'd0, 5'd1, 5'd3, 6'h22));
      load_i(3,  enc_i(6'h08, 5'd0, 5'd0, 16'd5));
      load_i(4,  enc_i(6'h2B, 5'd0, 5'd1, 16'd5));
      load_i(5,  enc_i(6'h23, 5'd0, 5'd4, 16'd5));
      load_i(6,  enc_i(6'h05, 5'd1, 5'd1, 16'd5));
      load_i(7,  enc_i(6'h05, 5'd1, 5'd0, 16'd2));
      load_i(8,  enc_i(6'h08, 5'd0, 5'd5, 16'd1));
      load_i(9,  enc_i(6'h08, 5'd0, 5'd5, 16'd1));
      load_i(10, enc_j(26'd3));
      kick();
      check("start_running", 32'(processor_running), 32'd1);
      check("start_pc", current_pc, 32'd0);
      exp_seq = '{1, 2, 3, 4, 5, 6, 7, 10, 3, 4, 5, 6, 7, 10, 3};
      for (int k = 0; k < 15; k++) begin
         tick();
         m_step();
         check("pc_seq", current_pc, exp_seq[k]);
      end
      check("addi_neg", dut.datapath_inst.reg_file.regs[1], 32'hFFFFFFFD);
      check("slt_signed", dut.datapath_inst.reg_file.regs[2], 32'd1);
      check("sub", dut.datapath_inst.reg_file.regs[3], 32'd3);
      check("reg0_zero", dut.datapath_inst.reg_file.regs[0], 32'd0);
      check("lw_roundtrip", dut.datapath_inst.reg_file.regs[4], 32'hFFFFFFFD);
      check("skipped_by_bne", dut.datapath_inst.reg_file.regs[5], 32'd0);
      check("sw_dmem5", dut.datapath_inst.r_dmem[5], 32'hFFFFFFFD);
      check("still_running", 32'(processor_running), 32'd1);
      for (int i = 0; i < 32; i++) check("alu_model_regs", dut.datapath_inst.reg_file.regs[i], m_regs[i]);

      rst = 1'b0;
      tick();
      m_reset();
      check("midrst_pc", current_pc, 32'd0);
      check("midrst_running", 32'(processor_running), 32'd0);
      check("midrst_reg1", dut.datapath_inst.reg_file.regs[1], 32'd0);
      check("midrst_reg4", dut.datapath_inst.reg_file.regs[4], 32'd0);
      check("midrst_dmem5", dut.datapath_inst.r_dmem[5], 32'hFFFFFFFD);
      check("midrst_imem0", current_instruction, 32'h2001FFFD);

      arr = '{32'd923, 32'd7, 32'd25, 32'd3, 32'd15, 32'd62, 32'd23, 32'd34, 32'd12, 32'd34};
      load_i(0,  enc_i(6'h08, 5'd0, 5'd10, 16'd10));
      load_i(1,  enc_i(6'h08, 5'd0, 5'd9, 16'd0));
      load_i(2,  enc_i(6'h23, 5'd0, 5'd8, 16'd0));
      load_i(3,  enc_i(6'h04, 5'd9, 5'd10, 16'd6));
      load_i(4,  enc_i(6'h23, 5'd9, 5'd11, 16'd0));
      load_i(5,  enc_r(5'd8, 5'd11, 5'd12, 6'h2A));
      load_i(6,  enc_i(6'h04, 5'd12, 5'd0, 16'd1));
      load_i(7,  enc_r(5'd11, 5'd0, 5'd8, 6'h20));
      load_i(8,  enc_i(6'h08, 5'd9, 5'd9, 16'd1));
      load_i(9,  enc_j(26'd3));
      load_i(10, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
      for (int i = 0; i < 10; i++) load_d(i, arr[i]);

      for (int run = 0; run < 2; run++) begin
         if (run == 1) begin
            rst = 1'b0;
            tick();
            m_reset();
            arr[0] = 32'd12;
            load_d(0, arr[0]);
         end
         exp_max = '0;
         for (int i = 0; i < 10; i++) if (arr[i] > exp_max) exp_max = arr[i];
         rst = 1'b1;
         kick();
         for (int c = 0; c < 2000; c++) begin
            tick();
            m_step();
         end
         check("max_value", dut.datapath_inst.reg_file.regs[8], exp_max);
         check("max_count", dut.datapath_inst.reg_file.regs[9], 32'd10);
         check("max_model_r8", dut.datapath_inst.reg_file.regs[8], m_regs[8]);
         check("max_spin_pc", current_pc, 32'd10);
         check("max_running", 32'(processor_running), 32'd1);
      end
      check("max_dmem5_kept", dut.datapath_inst.r_dmem[5], 32'd62);

      for (int r = 0; r < 4; r++) begin
         rst = 1'b0;
         tick();
         m_reset();
         for (int a = 0; a < 64; a++) load_i(a, rand_instr());
         rst = 1'b1;
         kick();
         for (int c = 0; c < 200; c++) begin
            tick();
            m_step();
            check("rand_pc", current_pc, m_pc);
            if (c % 16 == 0) check("rand_instr", current_instruction, m_imem[m_pc]);
         end
         for (int i = 0; i < 32; i++) check("rand_regs", dut.datapath_inst.reg_file.regs[i], m_regs[i]);
         for (int a = 0; a < 256; a++) check("rand_dmem", dut.datapath_inst.r_dmem[a], m_dmem[a]);
      end

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
